// File: rtl/johnson_seq_pkg.sv
// Shared mode encoding and per-mode sequence period for the Johnson/ring/LFSR generator.
package johnson_seq_pkg;

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'b00,
        MODE_RING    = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    // Hold never advances phase, so a period of 1 keeps the counter pinned at 0.
    function automatic int period(mode_e mode, int width);
        case (mode)
            MODE_JOHNSON: return 2 * width;
            MODE_RING:    return width;
            MODE_LFSR:    return (1 << width) - 1;
            default:      return 1;
        endcase
    endfunction

endpackage

// File: rtl/johnson_seq_next.sv
// Combinational next-value and legality logic for one step of the sequence register.
module johnson_seq_next
    import johnson_seq_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             dir,
    output logic [WIDTH-1:0] q_next,
    output logic             legal
);

    logic [WIDTH-1:0] q_inv;
    assign q_inv = ~q;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        q_next = q;
        legal  = 1'b1;
        unique case (mode)
            MODE_JOHNSON: begin
                q_next = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
                // Legal Johnson words are ones packed against the LSB or against the MSB.
                legal  = ((q & (q + 1'b1)) == '0) || ((q_inv & (q_inv + 1'b1)) == '0);
            end
            MODE_RING: begin
                q_next = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
                legal  = (q != '0) && ((q & (q - 1'b1)) == '0);
            end
            MODE_LFSR: begin
                q_next = (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
                legal  = (q != '0);
            end
            MODE_HOLD: begin
                q_next = q;
                legal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/johnson_seq_gen.sv
// Johnson / ring / Galois-LFSR sequence generator with phase counter and wrap pulse.
// Define JOHNSON_SEQ_RECOVER_EN to force illegal states back to 1 with an err pulse.
module johnson_seq_gen
    import johnson_seq_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] phase,
    output logic             wrap,
    output logic             err
);

    mode_e            mode_cur;
    mode_e            prev_mode;
    logic [WIDTH-1:0] q_next;
    logic             legal;
    logic [WIDTH-1:0] phase_last;
    logic             step_req;
    logic             mode_changed;
    logic             do_recover;
    logic             err_q;

    assign mode_cur     = mode_e'(mode);
    assign step_req     = en && (mode_cur != MODE_HOLD);
    assign mode_changed = (mode_cur != prev_mode);
    assign phase_last   = WIDTH'(period(mode_cur, WIDTH) - 1);

    johnson_seq_next #(
        .WIDTH     (WIDTH),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_next (
        .q      (q),
        .mode   (mode_cur),
        .dir    (dir),
        .q_next (q_next),
        .legal  (legal)
    );

`ifdef JOHNSON_SEQ_RECOVER_EN
    assign do_recover = step_req && !legal;
    assign err        = err_q;
`else
    logic unused_legal;
    logic unused_err_q;
    assign unused_legal = legal;
    assign unused_err_q = err_q;
    assign do_recover   = 1'b0;
    assign err          = 1'b0;
`endif

    // rst_n is a synchronous, active-high reset despite its name.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            q         <= WIDTH'(1);
            phase     <= '0;
            wrap      <= 1'b0;
            err_q     <= 1'b0;
            prev_mode <= MODE_JOHNSON;
        end else begin
            prev_mode <= mode_cur;
            wrap      <= 1'b0;
            err_q     <= 1'b0;
            if (load) begin
                q     <= load_val;
                phase <= '0;
            end else if (mode_changed) begin
                // A mode switch restarts the phase count even when it also steps.
                phase <= '0;
                if (do_recover) begin
                    q     <= WIDTH'(1);
                    err_q <= 1'b1;
                end else if (step_req) begin
                    q <= q_next;
                end
            end else if (step_req) begin
                if (do_recover) begin
                    q     <= WIDTH'(1);
                    phase <= '0;
                    err_q <= 1'b1;
                end else begin
                    q <= q_next;
                    if (phase == phase_last) begin
                        phase <= '0;
                        wrap  <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Self-checking bench for johnson_seq_gen at WIDTH=4, LFSR_TAPS=4'hC (honours JOHNSON_SEQ_RECOVER_EN).
module tb_johnson_seq_gen;

    localparam int W    = 4;
    localparam int TAPS = 4'hC;
    localparam int MASK = (1 << W) - 1;
`ifdef JOHNSON_SEQ_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic [W-1:0] phase;
    logic         wrap;
    logic         err;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [W-1:0] e_q;
    logic [W-1:0] e_ph;
    logic         e_w;
    logic         e_e;

    // Reference model state
    int m_q, m_phase, m_prev;
    bit m_wrap, m_err;
    bit jlegal [16];

    johnson_seq_gen #(.WIDTH(W), .LFSR_TAPS(4'hC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase    (phase),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_period(int md);
        case (md)
            0: return 2 * W;
            1: return W;
            2: return (1 << W) - 1;
            default: return 1;
        endcase
    endfunction

    function automatic int ref_next(int md, int d, int v);
        case (md)
            0: return d ? (((v >> 1) | ((~v & 1) << (W - 1))) & MASK)
                        : (((v << 1) | ((~v >> (W - 1)) & 1)) & MASK);
            1: return d ? (((v >> 1) | ((v & 1) << (W - 1))) & MASK)
                        : (((v << 1) | (v >> (W - 1))) & MASK);
            2: return (v >> 1) ^ ((v & 1) ? TAPS : 0);
            default: return v;
        endcase
    endfunction

    function automatic bit ref_legal(int md, int v);
        case (md)
            0: return jlegal[v];
            1: return $countones(v[W-1:0]) == 1;
            2: return v != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit ld, input bit e, input int md,
                              input bit d, input int lv);
        bit mc, stepping, ok;
        int nq;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_q = 1; m_phase = 0; m_prev = 0;
            return;
        end
        mc     = (md != m_prev);
        m_prev = md;
        if (ld) begin
            m_q = lv; m_phase = 0;
            return;
        end
        stepping = e && (md != 3);
        nq = ref_next(md, d, m_q);
        ok = ref_legal(md, m_q);
        if (mc) begin
            m_phase = 0;
            if (stepping) begin
                if (RECOVER && !ok) begin m_q = 1; m_err = 1'b1; end
                else m_q = nq;
            end
            return;
        end
        if (!stepping) return;
        if (RECOVER && !ok) begin
            m_q = 1; m_phase = 0; m_err = 1'b1;
        end else begin
            m_q     = nq;
            m_phase = (m_phase + 1) % ref_period(md);
            m_wrap  = (m_phase == 0);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; dir = 1'b0; load_val = '0;
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'b1010; mode = 2'b10; dir = 1'b1;
        tick();
        total_cnt++;
        if ({q, phase, wrap, err} !== {4'b0001, 4'b0000, 1'b0, 1'b0})
            $display("FAIL reset: q=%b phase=%0d wrap=%b err=%b, required q=0001 phase=0 wrap=0 err=0",
                     q, phase, wrap, err);
        else pass_cnt++;
        rst_n = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_johnson_up;
        int seq [8] = '{3, 7, 15, 14, 12, 8, 0, 1};
        do_reset();
        mode = 2'b00; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e_q = 4'(seq[i]); e_ph = 4'((i + 1) % 8); e_w = (i == 7); e_e = 1'b0;
            total_cnt++;
            if ({q, phase, wrap, err} !== {e_q, e_ph, e_w, e_e})
                $display("FAIL johnson_up[%0d]: q=%b ph=%0d w=%b e=%b, required q=%b ph=%0d w=%b e=%b",
                         i, q, phase, wrap, err, e_q, e_ph, e_w, e_e);
            else pass_cnt++;
        end
    endtask

    task automatic test_johnson_down;
        int seq [4] = '{0, 8, 12, 14};
        do_reset();
        mode = 2'b00; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            e_q = 4'(seq[i]); e_ph = 4'(i + 1); e_w = 1'b0; e_e = 1'b0;
            total_cnt++;
            if ({q, phase, wrap, err} !== {e_q, e_ph, e_w, e_e})
                $display("FAIL johnson_down[%0d]: q=%b ph=%0d w=%b e=%b, required q=%b ph=%0d w=%b e=%b",
                         i, q, phase, wrap, err, e_q, e_ph, e_w, e_e);
            else pass_cnt++;
        end
    endtask

    task automatic test_ring_and_switch;
        int seq [4] = '{2, 4, 8, 1};
        do_reset();
        mode = 2'b01; dir = 1'b0; en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            en = 1'b1;
            tick();
            e_q = 4'(seq[i]); e_ph = 4'((i + 1) % 4); e_w = (i == 3); e_e = 1'b0;
            total_cnt++;
            if ({q, phase, wrap, err} !== {e_q, e_ph, e_w, e_e})
                $display("FAIL ring[%0d]: q=%b ph=%0d w=%b e=%b, required q=%b ph=%0d w=%b e=%b",
                         i, q, phase, wrap, err, e_q, e_ph, e_w, e_e);
            else pass_cnt++;
        end
        // One more ring step so phase is nonzero before the switch.
        tick();
        mode = 2'b10;
        tick();
        total_cnt++;
        if ({q, phase, wrap} !== {4'b0001, 4'd0, 1'b0})
            $display("FAIL mode_switch: q=%b ph=%0d w=%b, required q=0001 ph=0 w=0", q, phase, wrap);
        else pass_cnt++;
    endtask

    task automatic test_lfsr;
        bit seen [16];
        int v;
        bit ok;
        do_reset();
        mode = 2'b10; en = 1'b0;
        tick();
        en = 1'b1;
        v  = 1;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            v = (v >> 1) ^ ((v & 1) ? TAPS : 0);
            if (q !== 4'(v) || q == 4'd0 || seen[q] || phase !== 4'((i + 1) % 15)) ok = 1'b0;
            else seen[q] = 1'b1;
        end
        total_cnt++;
        if (!ok || q !== 4'b0001 || wrap !== 1'b1)
            $display("FAIL lfsr_period: seq_ok=%b q=%b wrap=%b, required seq_ok=1 q=0001 wrap=1", ok, q, wrap);
        else pass_cnt++;
        en = 1'b0; load = 1'b1; load_val = 4'b0000;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        e_q = RECOVER ? 4'b0001 : 4'b0000; e_ph = RECOVER ? 4'd0 : 4'd1; e_w = 1'b0; e_e = RECOVER;
        total_cnt++;
        if ({q, phase, wrap, err} !== {e_q, e_ph, e_w, e_e})
            $display("FAIL lfsr_zero: q=%b ph=%0d w=%b e=%b, required q=%b ph=%0d w=%b e=%b",
                     q, phase, wrap, err, e_q, e_ph, e_w, e_e);
        else pass_cnt++;
    endtask

    task automatic test_load_then_reset;
        do_reset();
        mode = 2'b00; en = 1'b1; load = 1'b1; load_val = 4'b0101;
        tick();
        total_cnt++;
        if ({q, phase, wrap} !== {4'b0101, 4'd0, 1'b0})
            $display("FAIL load: q=%b ph=%0d w=%b, required q=0101 ph=0 w=0", q, phase, wrap);
        else pass_cnt++;
        load = 1'b0; rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        total_cnt++;
        if ({q, phase} !== {4'b0001, 4'd0})
            $display("FAIL reset_override: q=%b ph=%0d, required q=0001 ph=0", q, phase);
        else pass_cnt++;
    endtask

    task automatic test_ring_illegal;
        do_reset();
        mode = 2'b01; en = 1'b0;
        tick();
        load = 1'b1; load_val = 4'b0011;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        e_q = RECOVER ? 4'b0001 : 4'b0110; e_ph = RECOVER ? 4'd0 : 4'd1; e_e = RECOVER;
        total_cnt++;
        if ({q, phase, err} !== {e_q, e_ph, e_e})
            $display("FAIL ring_illegal: q=%b ph=%0d e=%b, required q=%b ph=%0d e=%b",
                     q, phase, err, e_q, e_ph, e_e);
        else pass_cnt++;
        en = 1'b0;
        tick();
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL err_pulse_width: err=%b, required 0", err);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int v = 0;
        int md = 0;
        int bad = 0;
        for (int i = 0; i < 2 * W; i++) begin
            jlegal[v] = 1'b1;
            v = ref_next(0, 0, v);
        end
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        model_step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) md = $urandom_range(0, 3);
            rst_n    = ($urandom_range(0, 79) == 0);
            load     = ($urandom_range(0, 15) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            mode     = 2'(md);
            load_val = 4'($urandom_range(0, 15));
            tick();
            model_step(rst_n, load, en, md, dir, int'(load_val));
            total_cnt++;
            if ({q, phase, wrap, err} !== {4'(m_q), 4'(m_phase), m_wrap, m_err}) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: q=%b ph=%0d w=%b e=%b, required q=%b ph=%0d w=%b e=%b",
                             i, q, phase, wrap, err, 4'(m_q), m_phase, m_wrap, m_err);
            end else pass_cnt++;
        end
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; load = 1'b0; load_val = '0;
        tick();
        test_reset();
        test_johnson_up();
        test_johnson_down();
        test_ring_and_switch();
        test_lfsr();
        test_load_then_reset();
        test_ring_illegal();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
